// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: oversampling ratio, vote tick
// indices, byte FSM encoding and the per-rate baud divider table.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int DIV_W      = 16;

  localparam logic [TICK_W-1:0] SAMPLE_T0 = TICK_W'(7);
  localparam logic [TICK_W-1:0] SAMPLE_T1 = TICK_W'(8);
  localparam logic [TICK_W-1:0] SAMPLE_T2 = TICK_W'(9);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  // Each branch folds to a constant once clk_freq is a parameter.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [2:0] baud_set);
    logic [DIV_W-1:0] d;
    case (baud_set)
      3'd0:    d = DIV_W'(clk_freq / (9600 * OVERSAMPLE) - 1);
      3'd1:    d = DIV_W'(clk_freq / (19200 * OVERSAMPLE) - 1);
      3'd2:    d = DIV_W'(clk_freq / (38400 * OVERSAMPLE) - 1);
      3'd3:    d = DIV_W'(clk_freq / (57600 * OVERSAMPLE) - 1);
      default: d = DIV_W'(clk_freq / (115200 * OVERSAMPLE) - 1);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, 16x oversampling divider, byte FSM and
// 3-sample majority vote. byte_valid / frame_err pulse one cycle after the stop vote.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [2:0] baud_set,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  rx_state_e         state, state_nx;
  logic              rx_meta, rx_sync, rx_prev;
  logic              start_edge;
  logic [DIV_W-1:0]  div_lat, div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick, vote_tick, vote;
  logic              v0, v1;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign tick       = (state != S_IDLE) && (div_cnt == div_lat);
  assign vote_tick  = tick && (tick_cnt == SAMPLE_T2);
  assign vote       = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Every state decision is taken at the vote tick, so the stop bit releases
  // the FSM at mid-bit and a back-to-back start edge is not missed.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_edge) state_nx = S_START;
      S_START: if (vote_tick) state_nx = vote ? S_IDLE : S_DATA;
      S_DATA:  if (vote_tick && (bit_idx == 3'd7)) state_nx = S_STOP;
      S_STOP:  if (vote_tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat    <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      v0         <= 1'b1;
      v1         <= 1'b1;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        if (start_edge) div_lat <= baud_div(CLK_FREQ, baud_set);
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 1'b1;
        if (tick_cnt == SAMPLE_T0) v0 <= rx_sync;
        if (tick_cnt == SAMPLE_T1) v1 <= rx_sync;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (vote_tick) begin
        case (state)
          S_START: bit_idx <= '0;
          S_DATA: begin
            shreg   <= {vote, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          S_STOP: begin
            byte_valid <= vote;
            frame_err  <= ~vote;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_byte   = shreg;
  assign state_dbg = state;

endmodule

// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: assembles DATA_WIDTH/8 bytes into one word with a Rx_Done pulse.
// Optional inter-byte timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_data_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int MSB_FIRST    = 0,
  parameter int CLK_FREQ     = 50000000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  uart_rx,
  input  logic [2:0]            Baud_Set,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  Rx_Done,
  output logic                  uart_state,
  output logic                  Frame_Err,
  output logic                  Rx_Timeout
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("uart_data_rx: DATA_WIDTH must be a multiple of 8 (>= 8) and TIMEOUT_BITS >= 1");
  end

  logic [7:0]            rx_byte;
  logic                  byte_valid, frame_err;
  logic [1:0]            rx_fsm;
  logic [CW-1:0]         count, slot;
  logic [DATA_WIDTH-1:0] shadow, shadow_merged;
  logic                  timeout_hit;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) u_byte_rx (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .rx         (uart_rx),
    .baud_set   (Baud_Set),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .state_dbg  (rx_fsm)
  );

  assign Frame_Err = frame_err;

  always_comb begin
    slot          = (MSB_FIRST != 0) ? (LAST - count) : count;
    shadow_merged = shadow;
    shadow_merged[{slot, 3'b000} +: 8] = rx_byte;
  end

  // The final byte goes straight into data via the merged view, so the shadow
  // never needs clearing between words.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data       <= '0;
      shadow     <= '0;
      count      <= '0;
      Rx_Done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      Rx_Done <= 1'b0;
      if (byte_valid) begin
        shadow <= shadow_merged;
        if (count == LAST) begin
          data       <= shadow_merged;
          Rx_Done    <= 1'b1;
          count      <= '0;
          uart_state <= 1'b0;
        end else begin
          count <= count + 1'b1;
        end
      end else if (frame_err || timeout_hit) begin
        count      <= '0;
        uart_state <= 1'b0;
      end
      if (rx_fsm == S_DATA) uart_state <= 1'b1;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TMO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TMO_W     = $clog2(TMO_TICKS + 1);

  logic [DIV_W-1:0] to_div, to_div_cnt;
  logic [TMO_W-1:0] idle_ticks;
  logic             idle_run;

  assign to_div      = baud_div(CLK_FREQ, Baud_Set);
  assign idle_run    = (count != '0) && (rx_fsm == S_IDLE);
  assign timeout_hit = idle_run && (idle_ticks == TMO_W'(TMO_TICKS));

  // Leaving IDLE (a start edge) stops idle_run and so clears the counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_div_cnt <= '0;
      idle_ticks <= '0;
      Rx_Timeout <= 1'b0;
    end else begin
      Rx_Timeout <= timeout_hit;
      if (!idle_run || timeout_hit) begin
        to_div_cnt <= '0;
        idle_ticks <= '0;
      end else if (to_div_cnt == to_div) begin
        to_div_cnt <= '0;
        idle_ticks <= idle_ticks + 1'b1;
      end else begin
        to_div_cnt <= to_div_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Rx_Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_data_rx.sv
// Bench for uart_data_rx: one serial line feeds an LSB-first and an MSB-first
// receiver; expected words are queued as bytes are sent and checked on Rx_Done.
`timescale 1ns/1ps
module tb_uart_data_rx;

  localparam int DW       = 32;
  localparam int NB       = DW / 8;
  localparam int CLK_HZ   = 7372800;
  localparam int TMO_BITS = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic [2:0]    baud_set;
  logic [DW-1:0] data0, data1;
  logic          done0, done1, state0, state1, ferr0, ferr1, tmo0, tmo1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int ferr_cnt0 = 0, ferr_cnt1 = 0;
  int tmo_cnt0 = 0, tmo_cnt1 = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] last0 = '0, last1 = '0;
  logic [DW-1:0] e0, e1;

  always #5 clk = ~clk;

  uart_data_rx #(.DATA_WIDTH(DW), .MSB_FIRST(0), .CLK_FREQ(CLK_HZ), .TIMEOUT_BITS(TMO_BITS)) dut_lsb (
    .Clk(clk), .Rst_n(rst_n), .uart_rx(uart_rx), .Baud_Set(baud_set),
    .data(data0), .Rx_Done(done0), .uart_state(state0), .Frame_Err(ferr0), .Rx_Timeout(tmo0)
  );

  uart_data_rx #(.DATA_WIDTH(DW), .MSB_FIRST(1), .CLK_FREQ(CLK_HZ), .TIMEOUT_BITS(TMO_BITS)) dut_msb (
    .Clk(clk), .Rst_n(rst_n), .uart_rx(uart_rx), .Baud_Set(baud_set),
    .data(data1), .Rx_Done(done1), .uart_state(state1), .Frame_Err(ferr1), .Rx_Timeout(tmo1)
  );

  function automatic int bit_clks(input logic [2:0] bs);
    int baud;
    case (bs)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      default: baud = 115200;
    endcase
    return (CLK_HZ / (baud * 16)) * 16;
  endfunction

  function automatic logic [DW-1:0] rev_bytes(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = w[(NB-1-i)*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*8 +: 8] = 8'($urandom_range(255));
    return w;
  endfunction

  // Scoreboard: seq[7:0] is the first byte on the wire.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done0) begin
        done_cnt0++;
        n_cmp++;
        if (exp_q0.size() == 0) begin
          n_bad++;
          $display("FAIL lsb_unexpected_done: data=%h, required no word", data0);
        end else begin
          e0 = exp_q0.pop_front();
          last0 = e0;
          if (data0 !== e0) begin
            n_bad++;
            $display("FAIL lsb_data: got %h, required %h", data0, e0);
          end
        end
        n_cmp++;
        if (state0 !== 1'b0) begin
          n_bad++;
          $display("FAIL lsb_state_at_done: got %b, required 0", state0);
        end
      end
      if (done1) begin
        done_cnt1++;
        n_cmp++;
        if (exp_q1.size() == 0) begin
          n_bad++;
          $display("FAIL msb_unexpected_done: data=%h, required no word", data1);
        end else begin
          e1 = exp_q1.pop_front();
          last1 = e1;
          if (data1 !== e1) begin
            n_bad++;
            $display("FAIL msb_data: got %h, required %h", data1, e1);
          end
        end
      end
      if (ferr0) ferr_cnt0++;
      if (ferr1) ferr_cnt1++;
      if (tmo0) tmo_cnt0++;
      if (tmo1) tmo_cnt1++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    int bc;
    bc = bit_clks(baud_set);
    uart_rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (bc) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (bc) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * bit_clks(baud_set)) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] seq);
    exp_q0.push_back(seq);
    exp_q1.push_back(rev_bytes(seq));
    for (int i = 0; i < NB; i++) send_byte(seq[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_done(input int target, input string name);
    int budget;
    budget = 20000;
    while ((done_cnt0 < target || done_cnt1 < target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (done_cnt0 != target || done_cnt1 != target) begin
      n_bad++;
      $display("FAIL %s_done_count: got %0d/%0d, required %0d", name, done_cnt0, done_cnt1, target);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({data0, done0, state0, ferr0, tmo0, data1, done1, state1, ferr1, tmo1} !== '0) begin
      n_bad++;
      $display("FAIL %s: data=%h/%h done=%b/%b state=%b/%b ferr=%b/%b tmo=%b/%b, required all 0",
               name, data0, data1, done0, done1, state0, state1, ferr0, ferr1, tmo0, tmo1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset_values");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [DW-1:0] seq;
    int d0, f0;
    seq = 32'h890a0987;
    d0 = done_cnt0;
    f0 = ferr_cnt0;
    exp_q0.push_back(seq);
    exp_q1.push_back(rev_bytes(seq));
    send_byte(seq[7:0], 1'b1);
    n_cmp++;
    if (state0 !== 1'b1 || state1 !== 1'b1) begin
      n_bad++;
      $display("FAIL single_state_mid: got %b/%b, required 1/1", state0, state1);
    end
    for (int i = 1; i < NB; i++) send_byte(seq[i*8 +: 8], 1'b1);
    n_cmp++;
    if (done_cnt0 != d0 + 1) begin
      n_bad++;
      $display("FAIL single_done_by_stop_end: got %0d, required %0d", done_cnt0, d0 + 1);
    end
    n_cmp++;
    if (ferr_cnt0 != f0 || state0 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ferr_state: ferr=%0d state=%b, required %0d / 0", ferr_cnt0, state0, f0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt0;
    for (int w = 0; w < 3; w++) send_word(rand_word());
    wait_done(d0 + 3, "b2b");
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_queue_drained: got %0d/%0d left, required 0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_glitch();
    logic [DW-1:0] seq;
    int d0, f0;
    d0 = done_cnt0;
    f0 = ferr_cnt0;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle_bits(2);
    n_cmp++;
    if (state0 !== 1'b0 || state1 !== 1'b0 || done_cnt0 != d0 || ferr_cnt0 != f0) begin
      n_bad++;
      $display("FAIL glitch_idle: state=%b/%b done=%0d ferr=%0d, required 0/0 %0d %0d",
               state0, state1, done_cnt0, ferr_cnt0, d0, f0);
    end
    seq = rand_word();
    exp_q0.push_back(seq);
    exp_q1.push_back(rev_bytes(seq));
    send_byte(seq[7:0], 1'b1);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle_bits(2);
    n_cmp++;
    if (state0 !== 1'b1 || state1 !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_midword_state: got %b/%b, required 1/1", state0, state1);
    end
    for (int i = 1; i < NB; i++) send_byte(seq[i*8 +: 8], 1'b1);
    wait_done(d0 + 1, "glitch");
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] junk;
    int d0, f0, f1;
    d0 = done_cnt0;
    f0 = ferr_cnt0;
    f1 = ferr_cnt1;
    junk = rand_word();
    send_byte(junk[7:0], 1'b1);
    send_byte(junk[15:8], 1'b1);
    send_byte(junk[23:16], 1'b0);
    idle_bits(1);
    n_cmp++;
    if (ferr_cnt0 != f0 + 1 || ferr_cnt1 != f1 + 1) begin
      n_bad++;
      $display("FAIL ferr_pulse_cycles: got %0d/%0d, required %0d/%0d", ferr_cnt0, ferr_cnt1, f0 + 1, f1 + 1);
    end
    n_cmp++;
    if (state0 !== 1'b0 || data0 !== last0 || data1 !== last1 || done_cnt0 != d0) begin
      n_bad++;
      $display("FAIL ferr_hold: state=%b data=%h/%h done=%0d, required 0 %h/%h %0d",
               state0, data0, data1, done_cnt0, last0, last1, d0);
    end
    send_word(rand_word());
    wait_done(d0 + 1, "ferr_recover");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] junk;
    int bc, d0;
    junk = rand_word();
    bc = bit_clks(baud_set);
    send_byte(junk[7:0], 1'b1);
    send_byte(junk[15:8], 1'b1);
    uart_rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = junk[16 + i];
      repeat (bc) @(negedge clk);
    end
    uart_rx = 1'b1;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs_zero("reset_midbyte");
    rst_n = 1'b1;
    last0 = '0;
    last1 = '0;
    done_cnt0 = 0;
    done_cnt1 = 0;
    d0 = 0;
    idle_bits(1);
    send_word(rand_word());
    wait_done(d0 + 1, "reset_recover");
  endtask

  task automatic test_timeout();
    logic [DW-1:0] seq;
    int d0, t0;
    d0 = done_cnt0;
    t0 = tmo_cnt0;
    seq = rand_word();
    send_byte(seq[7:0], 1'b1);
    send_byte(seq[15:8], 1'b1);
    idle_bits(25);
`ifdef UART_RX_TIMEOUT_EN
    n_cmp++;
    if (tmo_cnt0 != t0 + 1 || tmo_cnt1 != tmo_cnt0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got %0d/%0d, required %0d", tmo_cnt0, tmo_cnt1, t0 + 1);
    end
    n_cmp++;
    if (state0 !== 1'b0 || data0 !== last0 || done_cnt0 != d0) begin
      n_bad++;
      $display("FAIL timeout_hold: state=%b data=%h done=%0d, required 0 %h %0d", state0, data0, done_cnt0, last0, d0);
    end
    send_word(rand_word());
`else
    n_cmp++;
    if (tmo_cnt0 != t0 || tmo_cnt1 != 0 || state0 !== 1'b1 || state1 !== 1'b1) begin
      n_bad++;
      $display("FAIL no_timeout_wait: tmo=%0d/%0d state=%b/%b, required %0d/0 1/1", tmo_cnt0, tmo_cnt1, state0, state1, t0);
    end
    exp_q0.push_back(seq);
    exp_q1.push_back(rev_bytes(seq));
    for (int i = 2; i < NB; i++) send_byte(seq[i*8 +: 8], 1'b1);
`endif
    wait_done(d0 + 1, "timeout_word");
  endtask

  task automatic test_baud();
    logic [DW-1:0] seq;
    int d0, bc;
    d0 = done_cnt0;
    baud_set = 3'd3;
    send_word(rand_word());
    wait_done(d0 + 1, "baud_57600");
    baud_set = 3'd7;
    send_word(rand_word());
    wait_done(d0 + 2, "baud_code7");
    baud_set = 3'd4;
    bc = bit_clks(baud_set);
    seq = rand_word();
    exp_q0.push_back(seq);
    exp_q1.push_back(rev_bytes(seq));
    for (int i = 0; i < NB - 1; i++) send_byte(seq[i*8 +: 8], 1'b1);
    fork
      send_byte(seq[DW-1 -: 8], 1'b1);
      begin
        repeat (3 * bc) @(negedge clk);
        baud_set = 3'd0;
      end
    join
    baud_set = 3'd4;
    wait_done(d0 + 3, "baud_midbyte_change");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_timeout();
    test_baud();
    idle_bits(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
